gpio_spi_ctrl: RTL and testbench

SPI master controller that sequences 16-bit register transactions to the SPI-attached GPIO expander. It accepts one write or read command at a time from an on-chip requester over a valid/ready handshake and serializes it as an SPI frame (sclk, ss, mosi). It captures miso and returns a per-transaction response with read data. It sits between the system-side register/firmware logic and the expander's SPI pins.

---
 rtl/gpio_spi_ctrl_if.sv | 26 ++
 rtl/gpio_spi_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_gpio_spi_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_spi_ctrl_if.sv
// Command/response bus between a register-side requester and gpio_spi_ctrl.
//   master: drives cmd_* and receives cmd_ready / rsp_*
//   slave : the SPI controller side
interface gpio_spi_ctrl_if #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 8
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_wr;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [PDATA_WIDTH-1:0] cmd_wdata;
  logic                   rsp_valid;
  logic [PDATA_WIDTH-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/gpio_spi_ctrl.sv
// SPI master (mode 0) sequencing one 16-bit register transaction at a time
// to the SPI-attached GPIO expander.
// Ports:
//   clk, resetn  system clock, asynchronous active-low reset
//   bus          gpio_spi_ctrl_if.slave: cmd valid/ready + per-transaction response
//   sclk, ss     SPI clock (idle low) and active-low slave select
//   mosi, miso   SPI data out / in
// Optional feature: define GPIO_SPI_CTRL_VERIFY_EN to follow every write with
// an automatic readback frame and flag a mismatch on rsp_err.
module gpio_spi_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 8,
  parameter int unsigned CLK_DIV     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  gpio_spi_ctrl_if.slave    bus,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned FRAME_W = 1 + ADDR_WIDTH + PDATA_WIDTH;
  localparam int unsigned HALVES  = 2 * FRAME_W;
  localparam int unsigned HALF_W  = $clog2(HALVES);
  localparam int unsigned DIV_W   = 8;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALVES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [HALF_W-1:0]      half_q, half_d;
  logic [FRAME_W-1:0]     tx_q, tx_d;
  logic [PDATA_WIDTH-1:0] rx_q, rx_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [PDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   sclk_q, sclk_d;
  logic                   ss_q, ss_d;
  logic                   mosi_q, mosi_d;
  logic                   div_last;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
  logic                   wr_q, wr_d;
  logic                   vfy_q, vfy_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [PDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   rsp_err_q, rsp_err_d;
`endif

  assign div_last = (div_q == DIV_LAST);

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
    wr_d        = wr_q;
    vfy_d       = vfy_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          // Reads carry an all-zero data field
          tx_d        = {bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata & {PDATA_WIDTH{bus.cmd_wr}}};
          mosi_d      = bus.cmd_wr;
          ss_d        = 1'b0;
          cmd_ready_d = 1'b0;
          div_d       = '0;
          state_d     = S_SETUP;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
          wr_d        = bus.cmd_wr;
          vfy_d       = 1'b0;
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
`endif
        end
      end
      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q == HALF_LAST) begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end else if (!half_q[0]) begin
            // Rising sclk: sample miso in the same cycle sclk goes high
            sclk_d = 1'b1;
            rx_d   = {rx_q[PDATA_WIDTH-2:0], miso};
          end else begin
            // Falling sclk: present the next frame bit
            sclk_d = 1'b0;
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
            mosi_d = tx_q[FRAME_W-2];
          end
        end
      end
      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d   = '0;
          ss_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d       = '0;
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
          cmd_ready_d = 1'b1;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
          rsp_err_d   = vfy_q && (rx_q != wdata_q);
          if (wr_q) begin
            // Write just finished: launch the readback frame instead of responding
            state_d     = S_SETUP;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
            cmd_ready_d = 1'b0;
            tx_d        = {1'b0, addr_q, PDATA_WIDTH'(0)};
            mosi_d      = 1'b0;
            ss_d        = 1'b0;
            wr_d        = 1'b0;
            vfy_d       = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      half_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
      wr_q        <= 1'b0;
      vfy_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
      wr_q        <= wr_d;
      vfy_q       <= vfy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef GPIO_SPI_CTRL_VERIFY_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign sclk = sclk_q;
  assign ss   = ss_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_gpio_spi_ctrl.sv
// Self-checking bench for gpio_spi_ctrl: two instances (CLK_DIV=2 and 1)
// share one stimulus driver, one SPI slave model and one transaction checker.
module tb_gpio_spi_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          sel;          // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic          drv_valid;
  logic          drv_wr;
  logic [AW-1:0] drv_addr;
  logic [DW-1:0] drv_wdata;
  logic          slave_miso = 1'b0;

  gpio_spi_ctrl_if #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW)) bus2 ();
  gpio_spi_ctrl_if #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW)) bus1 ();

  assign bus2.cmd_valid = drv_valid & ~sel;
  assign bus2.cmd_wr    = drv_wr;
  assign bus2.cmd_addr  = drv_addr;
  assign bus2.cmd_wdata = drv_wdata;
  assign bus1.cmd_valid = drv_valid & sel;
  assign bus1.cmd_wr    = drv_wr;
  assign bus1.cmd_addr  = drv_addr;
  assign bus1.cmd_wdata = drv_wdata;

  logic sclk2, ss2, mosi2, sclk1, ss1, mosi1;

  gpio_spi_ctrl #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave),
    .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(slave_miso)
  );

  gpio_spi_ctrl #(.ADDR_WIDTH(AW), .PDATA_WIDTH(DW), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave),
    .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(slave_miso)
  );

  logic          obs_sclk, obs_ss, obs_mosi, obs_ready, obs_rsp_valid, obs_err;
  logic [DW-1:0] obs_rdata;
  assign obs_sclk      = sel ? sclk1 : sclk2;
  assign obs_ss        = sel ? ss1 : ss2;
  assign obs_mosi      = sel ? mosi1 : mosi2;
  assign obs_ready     = sel ? bus1.cmd_ready : bus2.cmd_ready;
  assign obs_rsp_valid = sel ? bus1.rsp_valid : bus2.rsp_valid;
  assign obs_rdata     = sel ? bus1.rsp_rdata : bus2.rsp_rdata;
  assign obs_err       = sel ? bus1.rsp_err : bus2.rsp_err;

  // SPI slave: shifts slave_word out MSB first (mode 0), records each frame seen
  logic [15:0] slave_word = 16'h0;
  logic [15:0] sl_sh = 16'h0;
  logic [15:0] sl_cap = 16'h0;
  int          sl_rises = 0;
  logic        p_ss = 1'b1;
  logic        p_sclk = 1'b0;
  logic [15:0] frm_q[$];
  int          rise_q[$];
  int          frm_rd = 0;

  always @(obs_ss or obs_sclk) begin
    if (p_ss && !obs_ss) begin
      sl_sh      = slave_word;
      slave_miso = sl_sh[15];
      sl_cap     = 16'h0;
      sl_rises   = 0;
    end else if (!p_ss && obs_ss) begin
      frm_q.push_back(sl_cap);
      rise_q.push_back(sl_rises);
    end
    if (!obs_ss && p_sclk && !obs_sclk) begin
      sl_sh      = {sl_sh[14:0], 1'b0};
      slave_miso = sl_sh[15];
    end
    if (!obs_ss && !p_sclk && obs_sclk) begin
      sl_cap   = {sl_cap[14:0], obs_mosi};
      sl_rises = sl_rises + 1;
    end
    p_ss   = obs_ss;
    p_sclk = obs_sclk;
  end

  // Length of the most recent ss-high interval, in clk cycles
  int hi_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (obs_ss) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  int checks = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on the selected instance, checked against the protocol rules
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [15:0] sword, input bit keep, input bit chk_gap);
    int d = sel ? 1 : 2;
    int budget = 0;
    int c = 0;
    bit got = 1'b0;
    int ss_lo = 0;
    int rdy_lo = 0;
    int hi = 0;
    int viol = 0;
    logic prev_mosi;
    logic [15:0] exp_f[$];
    int exp_lat;
    logic [DW-1:0] exp_rd;
    bit exp_err = 1'b0;
    int nf;

    while (!obs_ready && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_before_cmd", 32'(obs_ready), 32'd1);

    exp_f.push_back({wr, addr, wr ? wdata : 8'h00});
    exp_lat = 35 * d;
    exp_rd  = sword[7:0];
`ifdef GPIO_SPI_CTRL_VERIFY_EN
    if (wr) begin
      exp_f.push_back({1'b0, addr, 8'h00});
      exp_lat = 70 * d;
      exp_err = (sword[7:0] != wdata);
    end
`endif

    slave_word = sword;
    drv_wr     = wr;
    drv_addr   = addr;
    drv_wdata  = wdata;
    drv_valid  = 1'b1;
    prev_mosi  = obs_mosi;
    @(posedge clk);

    while (!got && c <= 80 * d) begin
      @(negedge clk);
      if (c == 0 && !keep) drv_valid = 1'b0;
      if (keep) begin
        drv_wr    = 1'($urandom);
        drv_addr  = 7'($urandom);
        drv_wdata = 8'($urandom);
      end
      if (!obs_ss) ss_lo++;
      if (!obs_ready) rdy_lo++;
      if (obs_sclk) hi++;
      if (obs_sclk && (obs_mosi !== prev_mosi)) viol++;
      prev_mosi = obs_mosi;
      if (c == 2 && chk_gap) chk("ss_gap_ge_div", 32'(last_gap >= d), 32'd1);
      if (obs_rsp_valid) got = 1'b1;
      else c++;
    end

    nf = exp_f.size();
    chk("rsp_valid_seen", 32'(got), 32'd1);
    chk("rsp_latency", 32'(c), 32'(exp_lat));
    chk("ss_low_cycles", 32'(ss_lo), 32'(nf * 34 * d));
    chk("ready_low_cycles", 32'(rdy_lo), 32'(exp_lat));
    chk("sclk_high_cycles", 32'(hi), 32'(nf * 16 * d));
    chk("mosi_change_sclk_high", 32'(viol), 32'd0);
    chk("rsp_rdata", 32'(obs_rdata), 32'(exp_rd));
    chk("rsp_err", 32'(obs_err), 32'(exp_err));
    chk("frame_count", 32'(frm_q.size() - frm_rd), 32'(nf));
    for (int i = 0; i < nf && (frm_rd + i) < frm_q.size(); i++) begin
      chk("frame_bits", 32'(frm_q[frm_rd + i]), 32'(exp_f[i]));
      chk("sclk_rises", 32'(rise_q[frm_rd + i]), 32'd16);
    end
    frm_rd = frm_q.size();

    if (!keep) begin
      @(negedge clk);
      chk("rsp_valid_pulse", 32'(obs_rsp_valid), 32'd0);
      chk("rdata_held", 32'(obs_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    int rv_cnt;
    int budget;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_wr    = 1'b0;
    drv_addr  = '0;
    drv_wdata = '0;
    resetn    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", 32'(obs_ready), 32'd1);
    chk("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(obs_rdata), 32'd0);
    chk("rst_rsp_err", 32'(obs_err), 32'd0);
    chk("rst_sclk", 32'(obs_sclk), 32'd0);
    chk("rst_ss", 32'(obs_ss), 32'd1);
    chk("rst_mosi", 32'(obs_mosi), 32'd0);
    chk("rst_ss_div1", 32'(ss1), 32'd1);

    resetn = 1'b1;
    @(negedge clk);
    frm_rd = frm_q.size();

    // Directed write / read at CLK_DIV=2
    run_txn(1'b1, 7'h20, 8'hFF, {8'($urandom), 8'hFF}, 1'b0, 1'b0);
    run_txn(1'b0, 7'h20, 8'($urandom), {8'($urandom), 8'hFF}, 1'b0, 1'b1);

    // cmd_valid held with changing fields: only the first command goes out
    run_txn(1'b1, 7'h15, 8'h3C, 16'($urandom), 1'b1, 1'b1);
    run_txn(1'b0, 7'h6A, 8'h00, 16'($urandom), 1'b0, 1'b1);

    // Reset in the middle of SHIFT after 7 sclk rises
    drv_wr    = 1'b1;
    drv_addr  = 7'h33;
    drv_wdata = 8'hC3;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    budget = 0;
    while (sl_rises < 7 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("rises_before_reset", 32'(sl_rises), 32'd7);
    resetn = 1'b0;
    #1;
    chk("midrst_ss", 32'(obs_ss), 32'd1);
    chk("midrst_sclk", 32'(obs_sclk), 32'd0);
    chk("midrst_mosi", 32'(obs_mosi), 32'd0);
    chk("midrst_ready", 32'(obs_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rv_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (obs_rsp_valid) rv_cnt++;
    end
    chk("no_rsp_after_reset", 32'(rv_cnt), 32'd0);
    frm_rd = frm_q.size();
    run_txn(1'b1, 7'h0F, 8'hA5, 16'($urandom), 1'b0, 1'b1);

    // CLK_DIV=1 instance
    sel = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 7'h40, 8'h5A, {8'($urandom), 8'h58}, 1'b0, 1'b1);

    // Randomized transactions across both instances
    for (int n = 0; n < 12; n++) begin
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom),
              1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
